// File: rtl/bit_ser_pkg.sv
// Shared types and constants for the bit serializer and its optional PRBS7 source.
package bit_ser_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PRBS} state_t;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  // Bit number idx of a w-bit word in transmit order.
  function automatic logic word_bit(input logic [63:0] word, input int w,
                                    input int idx, input logic msb_first);
    int pos;
    pos = msb_first ? (w - 1 - idx) : idx;
    return word[pos[5:0]];
  endfunction

endpackage

// File: rtl/bit_serializer_prbs7.sv
// PRBS7 (x^7 + x^6 + 1) Fibonacci LFSR; advances only while en is high.
module prbs7_gen
  import bit_ser_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_out
);

  logic [6:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= PRBS7_SEED;
    end else if (en) begin
      lfsr <= {lfsr[5:0], lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B]};
    end
  end

  assign bit_out = lfsr[6];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter with a one-word holding buffer for gapless output.
// Optional PRBS7 test-pattern mode is enabled by defining BIT_SER_PRBS_EN.
module bit_serializer
  import bit_ser_pkg::*;
#(
  parameter int   W         = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         word_done,
  output logic         underflow
`ifdef BIT_SER_PRBS_EN
  ,
  input  logic         prbs_mode
`endif
);

  localparam int              CNT_W  = $clog2(W);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(W - 2);

  state_t           state, state_n;
  logic [W-1:0]     hbuf, sreg, sreg_n;
  logic             hfull, hfull_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dout_n, dout_valid_n, word_done_n, underflow_n;
  logic             load, xfer, prbs_on, prbs_bit;

`ifdef BIT_SER_PRBS_EN
  assign prbs_on = prbs_mode;

  prbs7_gen u_prbs (
    .clk     (clk),
    .rst     (rst),
    .en      (prbs_mode),
    .bit_out (prbs_bit)
  );
`else
  assign prbs_on  = 1'b0;
  assign prbs_bit = 1'b0;
`endif

  assign din_ready = !hfull && !prbs_on;
  assign xfer      = din_valid && din_ready;

  always_comb begin
    state_n      = state;
    hfull_n      = hfull;
    cnt_n        = cnt;
    sreg_n       = sreg;
    dout_n       = dout;
    dout_valid_n = dout_valid;
    word_done_n  = 1'b0;
    underflow_n  = underflow;
    load         = 1'b0;

    if (prbs_on) begin
      state_n      = PRBS;
      dout_n       = prbs_bit;
      dout_valid_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hfull) begin
            load = 1'b1;
          end else begin
            dout_n       = IDLE_VAL;
            dout_valid_n = 1'b0;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            if (hfull) begin
              load = 1'b1;
            end else begin
              state_n      = IDLE;
              dout_n       = IDLE_VAL;
              dout_valid_n = 1'b0;
              underflow_n  = 1'b1;
            end
          end else begin
            cnt_n       = cnt + CNT_W'(1);
            dout_n      = word_bit(64'(sreg), W, 32'(cnt) + 1, MSB_FIRST);
            word_done_n = (cnt == PENULT);
          end
        end
        PRBS: begin
          state_n      = IDLE;
          dout_n       = IDLE_VAL;
          dout_valid_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end

    // A load empties the buffer; a transfer refills it. Both never coincide since ready = !hfull.
    if (load) begin
      sreg_n       = hbuf;
      hfull_n      = 1'b0;
      cnt_n        = '0;
      dout_n       = word_bit(64'(hbuf), W, 0, MSB_FIRST);
      dout_valid_n = 1'b1;
      state_n      = SHIFT;
    end
    if (xfer) hfull_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hfull      <= 1'b0;
      cnt        <= '0;
      dout       <= IDLE_VAL;
      dout_valid <= 1'b0;
      word_done  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_n;
      hfull      <= hfull_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      word_done  <= word_done_n;
      underflow  <= underflow_n;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) hbuf <= din;
    sreg <= sreg_n;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: queue-based behavioural model checked every cycle plus literal pins.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, dout, dout_valid, word_done, underflow;

  logic [7:0] din_l = 8'h00;
  logic       din_valid_l = 1'b0;
  logic       din_ready_l, dout_l, dout_valid_l, word_done_l, underflow_l;

`ifdef BIT_SER_PRBS_EN
  logic prbs_mode = 1'b0;
  logic prbs_mode_l = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .word_done(word_done), .underflow(underflow)
`ifdef BIT_SER_PRBS_EN
    , .prbs_mode(prbs_mode)
`endif
  );

  bit_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .dout(dout_l), .dout_valid(dout_valid_l), .word_done(word_done_l), .underflow(underflow_l)
`ifdef BIT_SER_PRBS_EN
    , .prbs_mode(prbs_mode_l)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending word buffer plus a queue of bits still to be shown for the current word.
  logic [7:0] m_buf;
  bit         m_full, m_dout, m_valid, m_done, m_under, m_init, m_rdy;
  bit         m_bits[$];
  bit         cmp_en = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_full  = 1'b0;
      m_bits.delete();
      m_dout  = 1'b0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_under = 1'b0;
      m_init  = 1'b1;
    end else begin
      m_rdy  = !m_full;
      m_done = 1'b0;
      if (m_bits.size() > 0) begin
        m_dout = m_bits.pop_front();
        m_done = (m_bits.size() == 0);
      end else if (m_full) begin
        for (int i = 7; i >= 0; i--) m_bits.push_back(m_buf[i]);
        m_dout  = m_bits.pop_front();
        m_valid = 1'b1;
        m_full  = 1'b0;
      end else begin
        if (m_valid) m_under = 1'b1;
        m_dout  = 1'b0;
        m_valid = 1'b0;
      end
      if (m_rdy && din_valid) begin
        m_buf  = din;
        m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init && cmp_en) begin
      check("model_dout", 16'(dout), 16'(m_dout));
      check("model_dout_valid", 16'(dout_valid), 16'(m_valid));
      check("model_word_done", 16'(word_done), 16'(m_done));
      check("model_underflow", 16'(underflow), 16'(m_under));
      check("model_din_ready", 16'(din_ready), 16'(!m_full));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] cap;
    logic [7:0]  dcap;
    int          ndone;
    bit          ps[127];

    repeat (3) step();
    rst = 1'b0;
    check("reset_dout", 16'(dout), 16'h0);
    check("reset_dout_valid", 16'(dout_valid), 16'h0);
    check("reset_underflow", 16'(underflow), 16'h0);
    check("reset_din_ready", 16'(din_ready), 16'h1);
    check("reset_word_done", 16'(word_done), 16'h0);

    // Single word 8'hA5, MSB first, then idle with underflow
    din = 8'hA5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("a5_ready_low", 16'(din_ready), 16'h0);
    cap = '0; dcap = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      cap[7-i] = dout;
      dcap[i]  = word_done;
      check("a5_valid", 16'(dout_valid), 16'h1);
    end
    check("a5_bits", cap, 16'h00A5);
    check("a5_word_done_pos", 16'(dcap), 16'h0080);
    step();
    check("a5_idle_dout", 16'(dout), 16'h0);
    check("a5_idle_valid", 16'(dout_valid), 16'h0);
    check("a5_underflow", 16'(underflow), 16'h1);

    // Back-to-back A5, 3C with din_valid held
    pulse_reset();
    din = 8'hA5; din_valid = 1'b1;
    step();
    din = 8'h3C;
    check("b2b_ready_after_accept", 16'(din_ready), 16'h0);
    cap = '0; ndone = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) check("b2b_ready_after_load", 16'(din_ready), 16'h1);
      if (i == 1) begin
        check("b2b_ready_after_second", 16'(din_ready), 16'h0);
        din_valid = 1'b0;
      end
      cap[15-i] = dout;
      if (word_done) ndone++;
      check("b2b_valid", 16'(dout_valid), 16'h1);
      check("b2b_no_underflow", 16'(underflow), 16'h0);
    end
    check("b2b_bits", cap, 16'hA53C);
    check("b2b_done_count", 16'(ndone), 16'd2);
    step();
    check("b2b_underflow", 16'(underflow), 16'h1);
    check("b2b_idle_valid", 16'(dout_valid), 16'h0);

    // LSB-first instance with 8'h01
    pulse_reset();
    din_l = 8'h01; din_valid_l = 1'b1;
    step();
    din_valid_l = 1'b0;
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      cap[7-i] = dout_l;
      check("lsb_valid", 16'(dout_valid_l), 16'h1);
    end
    check("lsb_bits", cap, 16'h0080);
    step();
    check("lsb_underflow", 16'(underflow_l), 16'h1);

    // Reset mid-word: FF shifting, 00 buffered
    pulse_reset();
    din = 8'hFF; din_valid = 1'b1;
    step();
    din = 8'h00;
    step();
    check("rst_mid_bit0", 16'(dout), 16'h1);
    step();
    din_valid = 1'b0;
    check("rst_mid_buffered", 16'(din_ready), 16'h0);
    step();
    check("rst_mid_bit2", 16'(dout), 16'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_dout", 16'(dout), 16'h0);
    check("rst_mid_valid", 16'(dout_valid), 16'h0);
    check("rst_mid_underflow", 16'(underflow), 16'h0);
    check("rst_mid_ready", 16'(din_ready), 16'h1);
    cap = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      cap = cap | 16'(dout_valid) | 16'(dout);
    end
    check("rst_mid_no_more_bits", cap, 16'h0);

`ifdef BIT_SER_PRBS_EN
    // PRBS7 reference: o[n+7] = o[n] ^ o[n+1], seed all ones
    for (int n = 0; n < 7; n++) ps[n] = 1'b1;
    for (int n = 0; n < 120; n++) ps[n+7] = ps[n] ^ ps[n+1];
    check("prbs_ref_pin", {ps[7], ps[8], ps[9], ps[10], ps[11], ps[12], ps[13], 9'h0},
          {7'b0000001, 9'h0});
    cmp_en = 1'b0;
    pulse_reset();
    prbs_mode = 1'b1;
    ndone = 0;
    for (int n = 0; n < 254; n++) begin
      step();
      if (dout !== ps[n % 127] || din_ready !== 1'b0 || dout_valid !== 1'b1) ndone++;
    end
    check("prbs_seq_errors", 16'(ndone), 16'd0);
    prbs_mode = 1'b0;
    step();
    check("prbs_exit_valid", 16'(dout_valid), 16'h0);
    pulse_reset();
    cmp_en = 1'b1;
`else
    ps[0] = 1'b0;
`endif

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
